i2s_rx: RTL and testbench
=========================

# i2s_rx

Synchronous I2S receiver: oversamples an external I2S bus (bit clock, word select, serial data) on the system clock and deserializes one stereo frame (left then right word, MSB-first) into an nBits-wide sample. It then issues a one-cycle write strobe into the audio sample FIFO. It is the capture end of the I2S audio path, the counterpart of the FIFO-fed I2S transmitter, and it fills the same nBits-wide sample buffer.

## Interface
- nBits, 32, frame width; each channel word is nBits/2 bits (nBits even, ≥ 4).
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bclk  input  1  I2S bit clock, asynchronous to clk; high and low phases each ≥ 2 clk periods.
- lrclk  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
- sdata  input  1  I2S serial data, asynchronous.
- full  input  1  FIFO full flag, synchronous to clk.
- dataOut  output  nBits  captured frame {left[nBits/2-1:0], right[nBits/2-1:0]}; registered.
- W  output  1  one-clk write strobe to FIFO; dataOut is valid whenever W = 1.
- overflow  output  1  sticky: a frame was dropped because full was high.

## Operation
- Synchronization: bclk, lrclk and sdata each pass through a 2-flop synchronizer.
- Edge detect: a third register on synchronized bclk flags a rising bit-clock edge (bedge) for one clk cycle.
- All capture happens only in bedge cycles. In each one, the block samples lr_now (synchronized lrclk) and bit (synchronized sdata), and holds lr_prev, the lr_now of the previous bedge.
- Word-boundary rule (I2S one-bit delay): when lr_now ≠ lr_prev, the bit sampled on that edge is the LSB of the word that is ending. The next bedge carries the MSB of the new word.
- Shift register per word, with a saturating bit counter cnt (width $clog2(nBits/2)+1):
  - If cnt < nBits/2, the bit is stored at position nBits/2-1-cnt; otherwise it is discarded, so the word is truncated to its MSBs.
  - At word end, unfilled LSB positions read 0 (short words are zero-padded).
  - cnt and the shift register clear at the start of each word.
- State machine:
  - ALIGN (reset state): discard all bits. On a bedge with lr_prev=1 and lr_now=0, go to LEFT with cnt=0.
  - LEFT: shift bits. On a bedge with lr_now ≠ lr_prev, shift in the final bit, latch the left word, clear cnt, and go to RIGHT.
  - RIGHT: shift bits. On a bedge with lr_now ≠ lr_prev, shift in the final bit and complete the frame, clear cnt, and go to LEFT.
- Frame emit, on the clk cycle after the completing bedge:
  - full=0: dataOut ← {left, right}, W=1 for exactly one cycle.
  - full=1: W stays 0, dataOut holds its previous value, overflow ← 1. The frame is lost.
- overflow clears only on rst.
- A rising edge of lr_prev→lr_now while in ALIGN is ignored. Alignment is always to the start of a left word.

## Timing
- Reset values: dataOut=0, W=0, overflow=0, state=ALIGN, cnt=0, shift registers=0, synchronizer/edge/lr_prev flops=0.
- rst asserted mid-frame aborts the partial frame on the next clk edge. After rst releases, no W is issued until a full left+right frame has been captured after the next 1→0 lrclk transition.
- Latency from bclk pin rising edge to bedge is 3 clk cycles (2 sync + 1 edge register). W asserts in the following cycle, 4 clk cycles after the completing bclk rising edge.
- W is never asserted on two consecutive cycles. Minimum W spacing is one frame time.
- full is sampled only in the emit cycle. A full that changes during the frame has no effect.
- An lrclk transition inside the first bit of a word (a 1-bit word) is legal: that word is {bit, zeros}.

## Test plan
- Reset: hold rst 3 cycles with the bus toggling → dataOut=0, W=0, overflow=0. No W within two frames after release if no 1→0 lrclk edge occurs.
- Nominal: bclk=clk/8, 16-bit words, left 0xA5C3, right 0x1234, preceded by one alignment frame → exactly one W per frame, dataOut=0xA5C31234, W 4 clk cycles after the right LSB bclk rising edge.
- Mid-frame start: begin stimulus halfway through a right word → no W for the partial frame. The first W carries the next complete frame's value.
- Word length mismatch:
  - 24-bit words, left 0xABCDEF, right 0x123456 → dataOut=0xABCD1234.
  - 8-bit words, left 0x81, right 0x7E → dataOut=0x81007E00.
- Overflow: full=1 in the emit cycle of frame 0x11112222 → W stays 0, dataOut unchanged, overflow=1. Next frame 0x33334444 with full=0 → W=1, dataOut=0x33334444, overflow still 1.
- Reset mid-frame: assert rst during a left word → no W for that frame, overflow=0. The next aligned frame is captured correctly.

Source files
------------

// File: rtl/i2s_rx_if.sv
// I2S bus pins plus the FIFO write side of the I2S receiver.
interface i2s_rx_if #(parameter int nBits = 32);
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic             full;
  logic [nBits-1:0] dataOut;
  logic             W;
  logic             overflow;

  modport master (output bclk, lrclk, sdata, full, input dataOut, W, overflow);
  modport slave  (input bclk, lrclk, sdata, full, output dataOut, W, overflow);
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdata on clk, deserializes a left+right
// frame MSB-first and writes it to the sample FIFO with a one-cycle strobe.
module i2s_rx #(
  parameter int nBits = 32
) (
  input  logic    clk,
  input  logic    rst,
  i2s_rx_if.slave bus
);

  localparam int H     = nBits / 2;
  localparam int CNT_W = $clog2(H) + 1;

  typedef enum logic [1:0] {ST_ALIGN, ST_LEFT, ST_RIGHT} state_t;

  state_t           r_state, w_state_next;
  logic             r_bclk_s1, r_bclk_s2, r_bclk_d, r_bedge;
  logic             r_lr_s1, r_lr_s2, r_lr_prev;
  logic             r_sd_s1, r_sd_s2;
  logic [CNT_W-1:0] r_cnt;
  logic [H-1:0]     r_shift, r_left, w_word_next;
  logic [nBits-1:0] r_data_out;
  logic             r_w, r_overflow;
  logic             w_lr_change, w_shift_en, w_left_done, w_frame_done;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_d  <= 1'b0;
      r_bedge   <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_lr_prev <= 1'b0;
      r_sd_s1   <= 1'b0;
      r_sd_s2   <= 1'b0;
    end else begin
      r_bclk_s1 <= bus.bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_bedge   <= r_bclk_s2 & ~r_bclk_d;
      r_lr_s1   <= bus.lrclk;
      r_lr_s2   <= r_lr_s1;
      r_sd_s1   <= bus.sdata;
      r_sd_s2   <= r_sd_s1;
      if (r_bedge) r_lr_prev <= r_lr_s2;
    end
  end

  // In a bedge cycle r_lr_s2 is lr_now and r_sd_s2 is the sampled bit.
  assign w_lr_change = r_lr_s2 != r_lr_prev;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ALIGN;
    else     r_state <= w_state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_left_done  = 1'b0;
    w_frame_done = 1'b0;
    if (r_bedge) begin
      case (r_state)
        ST_ALIGN: if (r_lr_prev && !r_lr_s2) w_state_next = ST_LEFT;
        ST_LEFT: begin
          w_shift_en = 1'b1;
          if (w_lr_change) begin
            w_left_done  = 1'b1;
            w_state_next = ST_RIGHT;
          end
        end
        ST_RIGHT: begin
          w_shift_en = 1'b1;
          if (w_lr_change) begin
            w_frame_done = 1'b1;
            w_state_next = ST_LEFT;
          end
        end
        default: w_state_next = ST_ALIGN;
      endcase
    end
  end

  // Current word with this edge's bit placed; bits past H are dropped.
  always_comb begin
    w_word_next = r_shift;
    for (int i = 0; i < H; i++) begin
      if (int'(r_cnt) == H - 1 - i) w_word_next[i] = r_sd_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_left     <= '0;
      r_data_out <= '0;
      r_w        <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_w <= 1'b0;
      if (w_shift_en) begin
        if (w_left_done || w_frame_done) begin
          r_cnt   <= '0;
          r_shift <= '0;
        end else begin
          r_shift <= w_word_next;
          if (r_cnt < CNT_W'(H)) r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_left_done) r_left <= w_word_next;
      // A frame that meets a full FIFO is dropped and remembered.
      if (w_frame_done) begin
        if (!bus.full) begin
          r_data_out <= {r_left, w_word_next};
          r_w        <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign bus.dataOut  = r_data_out;
  assign bus.W        = r_w;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bit-level I2S stimulus at bclk = clk/8 with a
// table of frames plus hand-written reset and alignment sequences.
module tb_i2s_rx;
  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2s_rx_if #(.nBits(NB)) bus();
  i2s_rx #(.nBits(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          w_count = 0;
  int          w_consec = 0;
  int          w_cyc = 0;
  int          rise_cyc = 0;
  logic        w_prev = 1'b0;
  logic [31:0] w_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed on the falling clock edge.
  always @(negedge clk) begin
    if (bus.W === 1'b1) begin
      w_count = w_count + 1;
      w_cyc   = cyc;
      w_data  = bus.dataOut;
      if (w_prev) w_consec = w_consec + 1;
    end
    w_prev = (bus.W === 1'b1);
  end

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          nb;
    logic        full;
    logic        exp_w;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bclk period: data/lrclk change on the falling edge, rise after 4 clks.
  task automatic send_bit(input logic b, input logic lr);
    bus.bclk  = 1'b0;
    bus.sdata = b;
    bus.lrclk = lr;
    repeat (4) @(negedge clk);
    bus.bclk = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  // lrclk flips on the LSB, one bit ahead of the next word's MSB.
  task automatic send_word(input logic [31:0] w, input int nb, input logic lr);
    for (int i = nb - 1; i >= 1; i--) send_bit(w[i], lr);
    send_bit(w[0], ~lr);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nb);
    send_word(l, nb, 1'b0);
    send_word(r, nb, 1'b1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.bclk  = 1'b0;
    bus.lrclk = 1'b0;
    bus.sdata = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          c0;
    logic [31:0] part_l;

    vecs[0] = '{32'h0000A5C3, 32'h00001234, 16, 1'b0, 1'b1, 32'hA5C31234, 1'b0};
    vecs[1] = '{32'h00005A5A, 32'h00000F0F, 16, 1'b0, 1'b1, 32'h5A5A0F0F, 1'b0};
    vecs[2] = '{32'h00ABCDEF, 32'h00123456, 24, 1'b0, 1'b1, 32'hABCD1234, 1'b0};
    vecs[3] = '{32'h00000081, 32'h0000007E,  8, 1'b0, 1'b1, 32'h81007E00, 1'b0};
    vecs[4] = '{32'h00001111, 32'h00002222, 16, 1'b1, 1'b0, 32'h81007E00, 1'b1};
    vecs[5] = '{32'h00003333, 32'h00004444, 16, 1'b0, 1'b1, 32'h33334444, 1'b1};
    vecs[6] = '{32'h00000001, 32'h00000001,  1, 1'b0, 1'b1, 32'h80008000, 1'b1};
    vecs[7] = '{32'h0000C0DE, 32'h0000F00D, 16, 1'b0, 1'b1, 32'hC0DEF00D, 1'b1};

    // Reset held three cycles while the bus toggles.
    rst       = 1'b1;
    bus.bclk  = 1'b0;
    bus.lrclk = 1'b0;
    bus.sdata = 1'b0;
    bus.full  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.bclk  = ~bus.bclk;
      bus.lrclk = ~bus.lrclk;
      bus.sdata = ~bus.sdata;
      @(negedge clk);
    end
    check("rst_dataOut", bus.dataOut, 32'h0);
    check("rst_W", {31'b0, bus.W}, 32'h0);
    check("rst_overflow", {31'b0, bus.overflow}, 32'h0);
    bus.bclk  = 1'b0;
    bus.lrclk = 1'b0;
    rst = 1'b0;

    // Two frames of bits with lrclk never falling: must stay unaligned.
    c0 = w_count;
    for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
    repeat (6) @(negedge clk);
    check("noalign_wcount", 32'(w_count - c0), 32'd0);
    check("noalign_overflow", {31'b0, bus.overflow}, 32'h0);

    // Alignment frame, then the vector table.
    do_reset();
    c0 = w_count;
    send_frame(32'hDEAD, 32'hBEEF, 16);
    repeat (6) @(negedge clk);
    check("align_frame_wcount", 32'(w_count - c0), 32'd0);

    for (int k = 0; k < 8; k++) begin
      bus.full = vecs[k].full;
      c0 = w_count;
      send_frame(vecs[k].l, vecs[k].r, vecs[k].nb);
      repeat (6) @(negedge clk);
      check($sformatf("v%0d_wcount", k), 32'(w_count - c0), vecs[k].exp_w ? 32'd1 : 32'd0);
      check($sformatf("v%0d_dataOut", k), bus.dataOut, vecs[k].exp_data);
      check($sformatf("v%0d_overflow", k), {31'b0, bus.overflow}, {31'b0, vecs[k].exp_ovf});
      if (vecs[k].exp_w) check($sformatf("v%0d_wdata", k), w_data, vecs[k].exp_data);
      if (k == 0) check("v0_latency", 32'(w_cyc - rise_cyc), 32'd4);
      bus.full = 1'b0;
    end

    // Reset in the middle of a left word.
    part_l = 32'h00001111;
    for (int i = 15; i >= 8; i--) send_bit(part_l[i], 1'b0);
    c0 = w_count;
    do_reset();
    check("midrst_overflow", {31'b0, bus.overflow}, 32'h0);
    for (int i = 7; i >= 1; i--) send_bit(part_l[i], 1'b0);
    send_bit(part_l[0], 1'b1);
    send_word(32'h2222, 16, 1'b1);
    repeat (6) @(negedge clk);
    check("midrst_wcount", 32'(w_count - c0), 32'd0);
    check("midrst_dataOut", bus.dataOut, 32'h0);
    c0 = w_count;
    send_frame(32'h9876, 32'h5432, 16);
    repeat (6) @(negedge clk);
    check("midrst_next_wcount", 32'(w_count - c0), 32'd1);
    check("midrst_next_dataOut", bus.dataOut, 32'h98765432);

    // Start halfway through a right word.
    do_reset();
    c0 = w_count;
    for (int i = 0; i < 7; i++) send_bit(1'(i & 1), 1'b1);
    send_bit(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("midstart_partial_wcount", 32'(w_count - c0), 32'd0);
    send_frame(32'h2468, 32'h1357, 16);
    repeat (6) @(negedge clk);
    check("midstart_wcount", 32'(w_count - c0), 32'd1);
    check("midstart_dataOut", bus.dataOut, 32'h24681357);

    check("w_consecutive", 32'(w_consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
